md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_pkg.sv | 37 +++
 rtl/md_sequencer_divider.sv | 69 ++++++
 rtl/md_sequencer.sv | 118 +++++++++++
 tb/tb_md_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the M-extension sequencer: instruction layout,
// opcode/funct codes, multiplier latency, divider defaults and FSM states.
package md_sequencer_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] M_INSTR   = 7'b0000001;

  // funct3 codes: bit 2 separates multiply (0) from divide (1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MUL_LATENCY        = 3;
  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_RUN  = 2'd2,
    S_DONE     = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_sequencer_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Only built when RV32M_DIV_EN is defined.
`ifdef RV32M_DIV_EN
module md_divider
  import md_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   quo, rem, dvs;
  logic          neg_q, neg_r;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag;
  logic [32:0]   r_sh, diff;

  assign a_neg = is_signed & dividend[31];
  assign b_neg = is_signed & divisor[31];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder
  assign r_sh = {rem, quo[31]};
  assign diff = r_sh - {1'b0, dvs};
  assign busy = (cnt != '0);

  // Load operands (or a special-case answer) on start, then iterate while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; quo <= '0; rem <= '0; dvs <= '0; neg_q <= 1'b0; neg_r <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      if (divisor == '0) begin
        quo <= '1; rem <= dividend; neg_q <= 1'b0; neg_r <= 1'b0; cnt <= '0;
      end else if (is_signed && dividend == 32'h8000_0000 && divisor == '1) begin
        quo <= 32'h8000_0000; rem <= '0; neg_q <= 1'b0; neg_r <= 1'b0; cnt <= '0;
      end else begin
        quo <= a_mag; rem <= '0; dvs <= b_mag;
        neg_q <= a_neg ^ b_neg; neg_r <= a_neg;
        cnt <= CW'(DIV_CYCLES);
      end
    end else if (busy) begin
      if (!diff[32]) begin
        rem <= diff[31:0]; quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= r_sh[31:0]; quo <= {quo[30:0], 1'b0};
      end
      cnt <= cnt - 1'b1;
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule
`endif

// File: rtl/md_sequencer.sv
// M-extension sequencer: holds EX operands toward an external multiplier or
// runs the iterative divider, stalls the front end, and pulses done.
// Macro RV32M_DIV_EN includes the divider; without it divides flag md_illegal.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        flush,
  input  instr_t      instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        mul_valid,
  input  logic [31:0] mul_result,
  output instr_t      mul_instr,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        md_illegal
);
  md_state_t   state;
  instr_t      instr_q;
  logic [31:0] op_a, op_b, result_q;
  logic        illegal_q;
  logic        req, is_div;

  assign req    = ex_valid & ~flush & (instr.opcode == OPC_RTYPE) & (instr.funct7 == M_INSTR);
  assign is_div = instr.funct3[2];

`ifdef RV32M_DIV_EN
  logic        div_busy;
  logic [31:0] div_q, div_r;

  // Divider is loaded straight from the EX operands in the request cycle
  md_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     ((state == S_IDLE) & req & is_div),
    .abort     (flush),
    .dividend  (rs1_data),
    .divisor   (rs2_data),
    .is_signed (~instr.funct3[0]),
    .busy      (div_busy),
    .quotient  (div_q),
    .remainder (div_r)
  );
`else
  localparam int div_cycles_unused = DIV_CYCLES;
`endif

  // Sequencer state, operand latches and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE; instr_q <= '0; op_a <= '0; op_b <= '0;
      result_q <= '0; illegal_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (req) begin
          instr_q <= instr; op_a <= rs1_data; op_b <= rs2_data; illegal_q <= 1'b0;
          if (!is_div) state <= S_MUL_WAIT;
`ifdef RV32M_DIV_EN
          else state <= S_DIV_RUN;
`else
          else begin
            state <= S_DONE; result_q <= '0; illegal_q <= 1'b1;
          end
`endif
        end
        S_MUL_WAIT: if (mul_valid) begin
          result_q <= mul_result; state <= S_DONE;
        end
        S_DIV_RUN: begin
`ifdef RV32M_DIV_EN
          // busy drops one cycle after the last iteration (or at once for special cases)
          if (!div_busy) begin
            result_q <= instr_q.funct3[1] ? div_r : div_q;
            state <= S_DONE;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          state <= S_IDLE; illegal_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Freeze the front end from the request cycle until DONE; flush releases it
  always_comb begin
    stall = 1'b0;
    if (!flush) begin
      case (state)
        S_IDLE:                stall = req;
        S_MUL_WAIT, S_DIV_RUN: stall = 1'b1;
        default:               stall = 1'b0;
      endcase
    end
  end

  // Zero instr outside MUL_WAIT restarts the multiplier's internal counter
  assign mul_instr  = (state == S_MUL_WAIT) ? instr_q : '0;
  assign mul_a      = op_a;
  assign mul_b      = op_b;
  assign result     = result_q;
  assign done       = (state == S_DONE) & ~flush;
  assign md_illegal = (state == S_DONE) & illegal_q & ~flush;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed and random M-ops against a
// reference computed from plain arithmetic, plus flush and reset scenarios.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int DIV_CYCLES = 32;

  logic        clk, rst, ex_valid, flush, mul_valid, stall, done, md_illegal;
  instr_t      instr, mul_instr;
  logic [31:0] rs1_data, rs2_data, mul_result, mul_a, mul_b, result;

  int n_chk, n_pass;
  int mcnt;

  md_sequencer #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush(flush), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .mul_valid(mul_valid),
    .mul_result(mul_result), .mul_instr(mul_instr), .mul_a(mul_a), .mul_b(mul_b),
    .stall(stall), .done(done), .result(result), .md_illegal(md_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference M-extension result from 64-bit products and SV division
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] r;
    ea = {32'b0, a}; eb = {32'b0, b};
    if (f3 == F3_MULH || f3 == F3_MULHSU) ea = {{32{a[31]}}, a};
    if (f3 == F3_MULH) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (f3)
      F3_MUL:  r = p[31:0];
      F3_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a
                   : 32'($signed(a) / $signed(b));
      F3_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0
                   : 32'($signed(a) % $signed(b));
      F3_REMU: r = (b == 0) ? a : a % b;
      default: r = p[63:32];
    endcase
    return r;
  endfunction

  // Stand-in multiplier: result ready MUL_LATENCY cycles after it first sees an instr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcnt <= 0;
    else if (mul_instr == '0) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end
  assign mul_valid  = (mul_instr != '0) && (mcnt == MUL_LATENCY);
  assign mul_result = ref_md(mul_instr.funct3, mul_a, mul_b);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic instr_t mk_instr(input logic [2:0] f3, input logic [6:0] f7);
    instr_t i;
    i = '0;
    i.opcode = OPC_RTYPE; i.funct7 = f7; i.funct3 = f3;
    i.rd = 5'($urandom_range(1, 31));
    return i;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one M-op and check latency, stall coverage, result and illegal flag
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat, k, n_low;
    logic [31:0] exp_r;
    logic exp_ill;
    exp_ill = 1'b0;
    exp_r = ref_md(f3, a, b);
    if (!f3[2]) lat = MUL_LATENCY + 2;
`ifdef RV32M_DIV_EN
    else if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 2;
    else lat = DIV_CYCLES + 2;
`else
    else begin lat = 1; exp_r = 32'h0; exp_ill = 1'b1; end
`endif
    @(negedge clk);
    ex_valid = 1'b1; instr = mk_instr(f3, M_INSTR); rs1_data = a; rs2_data = b;
    #1 chk("stall_req", stall, 1);
    @(negedge clk);
    ex_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
    #1;
    k = 1; n_low = 0;
    while (done !== 1'b1 && k < 100) begin
      if (stall !== 1'b1) n_low++;
      @(negedge clk); #1;
      k++;
    end
    chk($sformatf("lat_f3_%0d", f3), k, lat);
    chk("stall_gap", n_low, 0);
    chk($sformatf("res_f3_%0d_%h_%h", f3, a, b), result, exp_r);
    chk("illegal", md_illegal, exp_ill);
    chk("stall_in_done", stall, 0);
    chk("mul_instr_in_done", mul_instr, 0);
    @(negedge clk); #1;
    chk("done_pulse", done, 0);
    chk("res_hold", result, exp_r);
  endtask

  // Flush on the 3rd cycle after issue; nothing may complete afterwards
  task automatic flush_op(input logic [2:0] f3);
    int nd;
    @(negedge clk);
    ex_valid = 1'b1; instr = mk_instr(f3, M_INSTR); rs1_data = $urandom; rs2_data = $urandom | 32'h1;
    @(negedge clk); ex_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); flush = 1'b1;
    #1 chk("flush_stall", stall, 0);
    chk("flush_done", done, 0);
    @(negedge clk); flush = 1'b0;
    #1 chk("flush_idle_stall", stall, 0);
    nd = 0;
    repeat (DIV_CYCLES + 8) begin @(negedge clk); nd += int'(done); end
    chk("flush_no_done", nd, 0);
  endtask

  // Reset in the middle of MUL_WAIT clears every output and drops the op
  task automatic reset_mid_mul();
    int nd;
    @(negedge clk);
    ex_valid = 1'b1; instr = mk_instr(F3_MUL, M_INSTR); rs1_data = 32'h1234_5678; rs2_data = 32'h9;
    @(negedge clk); ex_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst_stall", stall, 0); chk("rst_done", done, 0); chk("rst_ill", md_illegal, 0);
    chk("rst_result", result, 0); chk("rst_mul_instr", mul_instr, 0);
    chk("rst_mul_a", mul_a, 0); chk("rst_mul_b", mul_b, 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    repeat (12) begin @(negedge clk); nd += int'(done); end
    chk("rst_no_done", nd, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_stall", stall, 0); chk("init_done", done, 0); chk("init_result", result, 0);
    chk("init_mul_instr", mul_instr, 0); chk("init_ill", md_illegal, 0);
    @(negedge clk); rst = 1'b0;

    run_op(F3_MUL,   32'd7,          32'hFFFF_FFFD);
    run_op(F3_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(F3_DIV,   32'd100,        32'hFFFF_FFF9);
    run_op(F3_REM,   32'd100,        32'hFFFF_FFF9);
    run_op(F3_DIVU,  32'd5,          32'd0);
    run_op(F3_REM,   32'd5,          32'd0);
    run_op(F3_DIV,   32'h8000_0000,  32'hFFFF_FFFF);
    run_op(F3_REM,   32'h8000_0000,  32'hFFFF_FFFF);

    // Non-M instruction and a flushed request must not stall
    @(negedge clk);
    ex_valid = 1'b1; instr = mk_instr(F3_MUL, 7'b0000000);
    #1 chk("non_m_stall", stall, 0);
    @(negedge clk); ex_valid = 1'b1; flush = 1'b1; instr = mk_instr(F3_MUL, M_INSTR);
    #1 chk("flushed_req_stall", stall, 0);
    @(negedge clk); ex_valid = 1'b0; flush = 1'b0;
    #1 chk("no_req_done", done, 0);

    flush_op(F3_MULH);
`ifdef RV32M_DIV_EN
    flush_op(F3_DIV);
`endif
    run_op(F3_MUL, 32'd6, 32'd7);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    reset_mid_mul();
    run_op(F3_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
